serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 37 +++
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow result line.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, WIDTH cycles.
// SERIAL_ADDER_OVF_EN enables the registered signed-overflow output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic s_bit;
    logic c_nxt;

    assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

    // Next state: capture on start, add one bit per RUN cycle, publish at the last bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_nxt;
                sr_d  = {s_bit, sr_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {s_bit, sr_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the MSB while bit WIDTH-1 is added.
                    ovf_d   = c_q ^ c_nxt;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: timeline model plus directed literals.
// Checks ovf only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   cmp_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_busy = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: cycles since the accepting edge; -1 when idle.
    int           m_t = -1;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;

    always @(posedge clk) begin
        logic [W:0] full;
        int sgn;
        cyc++;
        if (reset) begin
            m_t = -1;
            m_sum = '0;
            m_cout = 1'b0;
            m_ovf = 1'b0;
        end else if (m_t < 0) begin
            if (bus.start) begin
                full = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
                p_sum = full[W-1:0];
                p_cout = full[W];
                sgn = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
                p_ovf = (sgn > (2 ** (W - 1)) - 1) || (sgn < -(2 ** (W - 1)));
                m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == W) begin
                m_sum = p_sum;
                m_cout = p_cout;
                m_ovf = p_ovf;
            end else if (m_t == W + 1) begin
                m_t = -1;
            end
        end
    end

    // Every cycle: compare DUT outputs with the model.
    always @(negedge clk) begin
        if (bus.done === 1'b1) n_done++;
        if (bus.busy === 1'b1) n_busy++;
        if (cmp_en) begin
            check("busy", 64'(bus.busy), 64'(m_t >= 0));
            check("done", 64'(bus.done), 64'(m_t == W));
            check("sum", 64'(bus.sum), 64'(m_sum));
            check("cout", 64'(bus.cout), 64'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 64'(bus.ovf), 64'(m_ovf));
`endif
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string nm);
        int k;
        @(posedge clk);
        #2;
        bus.a = a;
        bus.b = b;
        bus.cin = ci;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'($urandom);
        for (k = 0; k < 3 * W; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        check({nm, " latency"}, 64'(k), 64'(W));
        check({nm, " sum"}, 64'(bus.sum), 64'(es));
        check({nm, " cout"}, 64'(bus.cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({nm, " ovf"}, 64'(bus.ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("unexpected x ovf literal");
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int b0;
        int nd;
        int times[2];
        logic [W-1:0] sums[2];

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset sum", 64'(bus.sum), 64'(0));
        check("reset cout", 64'(bus.cout), 64'(0));

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "cin");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "minneg");

        // start while busy
        @(posedge clk);
        #2;
        bus.a = 8'h01;
        bus.b = 8'h01;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        d0 = n_done;
        b0 = n_busy;
        repeat (2) @(posedge clk);
        #2;
        bus.a = 8'h10;
        bus.b = 8'h10;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (2 * W + 4) @(posedge clk);
        @(negedge clk);
        check("busy-start dones", 64'(n_done - d0), 64'(1));
        check("busy-start sum", 64'(bus.sum), 64'(8'h02));
        check("busy-start busy cycles", 64'(n_busy - b0), 64'(W + 1));

        // reset mid-operation
        @(posedge clk);
        #2;
        bus.a = 8'h33;
        bus.b = 8'h44;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        d0 = n_done;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("midreset busy", 64'(bus.busy), 64'(0));
        check("midreset sum", 64'(bus.sum), 64'(0));
        repeat (W + 3) @(posedge clk);
        @(negedge clk);
        check("midreset no done", 64'(n_done - d0), 64'(0));
        run_op(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, "after-reset");

        // start held high: back-to-back
        @(posedge clk);
        #2;
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.a = 8'h40;
        bus.b = 8'h05;
        nd = 0;
        times[0] = 0;
        times[1] = 0;
        sums[0] = '0;
        sums[1] = '0;
        for (int k = 0; k < 6 * W && nd < 2; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                times[nd] = cyc;
                sums[nd] = bus.sum;
                nd++;
            end
        end
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        check("b2b dones", 64'(nd), 64'(2));
        check("b2b interval", 64'(times[1] - times[0]), 64'(W + 2));
        check("b2b first", 64'(sums[0]), 64'(8'h46));
        check("b2b second", 64'(sums[1]), 64'(8'h45));

        // randomized traffic, including starts while busy and rare resets
        d0 = n_done;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            bus.start = ($urandom % 3 == 0);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom);
            reset = ($urandom % 151 == 0);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        check("random saw results", 64'(n_done - d0 > 10), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
